// File: rtl/seven_seg_mux.sv
// seven_seg_mux: time-multiplexed N-digit seven-segment driver
// with double-buffered value, anti-ghost blanking and LZ suppression.
module seven_seg_mux #(
  parameter int N_DIGITS       = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load,
  input  logic                  lz_blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_done
);

  localparam int VW = 4 * N_DIGITS;
  localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CW = $clog2(REFRESH_DIV);

  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [DW-1:0] DIG_LAST  = DW'(N_DIGITS - 1);

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [CW-1:0]       div_cnt_q, div_cnt_d;
  logic [DW-1:0]       dig_q, dig_d;
  logic [VW-1:0]       pend_val_q, pend_val_d;
  logic [N_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic                pend_valid_q, pend_valid_d;
  logic [VW-1:0]       disp_val_q, disp_val_d;
  logic [N_DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic                frame_done_q, frame_done_d;

  logic                last_cnt;
  logic                boundary;
  logic [N_DIGITS-1:0] onehot;
  logic [N_DIGITS-1:0] supp;
  logic                hi_zero;
  logic [3:0]          nib;
  logic                sel_supp;

  // Refresh divider and digit scan counter
  always_comb begin
    last_cnt  = (div_cnt_q == CNT_LAST);
    boundary  = last_cnt && (dig_q == DIG_LAST);
    div_cnt_d = last_cnt ? '0 : div_cnt_q + 1'b1;
    dig_d     = dig_q;
    if (last_cnt) begin
      dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
    end
  end

  // Pending/display buffers; display only changes at a frame boundary
  always_comb begin
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    if (boundary && pend_valid_q) begin
      disp_val_d   = pend_val_q;
      disp_dp_d    = pend_dp_q;
      pend_valid_d = 1'b0;
    end
    if (load) begin
      pend_val_d   = value;
      pend_dp_d    = dp_in;
      pend_valid_d = 1'b1;
    end
  end

  // Leading-zero mask: digit k blank when nibbles k..top are all zero
  always_comb begin
    hi_zero = 1'b1;
    supp    = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      hi_zero = hi_zero & (disp_val_q[4*k +: 4] == 4'h0);
      supp[k] = hi_zero & ~disp_dp_q[k];
    end
    supp[0] = 1'b0;
  end

  // Next registered pin values (active-high internally)
  always_comb begin
    onehot       = N_DIGITS'(1) << dig_q;
    nib          = 4'(disp_val_q >> {dig_q, 2'b00});
    sel_supp     = lz_blank && |(supp & onehot);
    seg_d        = sel_supp ? 7'h00 : hex7(nib);
    dp_d         = ~sel_supp & |(disp_dp_q & onehot);
    an_d         = (div_cnt_q < BLANK_END) ? '0 : onehot;
    frame_done_d = boundary;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      dig_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      seg_q        <= '0;
      dp_q         <= 1'b0;
      an_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      dig_q        <= dig_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign dp         = (SEG_ACTIVE_LOW != 0) ? ~dp_q : dp_q;
  assign an         = (AN_ACTIVE_LOW != 0) ? ~an_q : an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_mux.sv
// tb_seven_seg_mux: scoreboard bench for seven_seg_mux
// with a cycle-count reference model and directed display checks.
module tb_seven_seg_mux;

  localparam int N   = 4;
  localparam int R   = 8;
  localparam int B   = 2;
  localparam int SAL = 0;
  localparam int AAL = 1;
  localparam int FR  = N * R;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        lz_blank;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  seven_seg_mux #(
    .N_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B),
    .SEG_ACTIVE_LOW(SAL), .AN_ACTIVE_LOW(AAL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in),
    .load(load), .lz_blank(lz_blank), .seg(seg), .dp(dp),
    .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                           7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                           7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: state is just cycles since reset plus two buffers
  int          t = 0;
  logic [15:0] pend_v = '0, disp_v = '0;
  logic [3:0]  pend_d = '0, disp_d = '0;
  bit          pv = 0;
  logic [12:0] sb [$];

  function automatic logic [12:0] pins(input logic [3:0] act,
                                       input logic [6:0] s,
                                       input logic d, input logic fd);
    logic [3:0] a;
    logic [6:0] sp;
    logic       dpp;
    a   = (AAL != 0) ? ~act : act;
    sp  = (SAL != 0) ? ~s : s;
    dpp = (SAL != 0) ? ~d : d;
    return {a, sp, dpp, fd};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      t = 0; pend_v = '0; pend_d = '0; pv = 0;
      disp_v = '0; disp_d = '0;
      sb.push_back(pins(4'b0000, 7'h00, 1'b0, 1'b0));
    end else begin
      int dg, dv;
      bit bnd, sup;
      logic [3:0] act, nb;
      logic [6:0] s;
      logic d;
      dg  = (t / R) % N;
      dv  = t % R;
      bnd = (dv == R - 1) && (dg == N - 1);
      nb  = 4'((disp_v >> (4 * dg)) & 16'hF);
      sup = lz_blank && dg != 0 && (disp_v >> (4 * dg)) == 0
            && !disp_d[dg];
      act = (dv < B) ? 4'b0000 : 4'(1 << dg);
      s   = sup ? 7'h00 : tbl[nb];
      d   = sup ? 1'b0 : disp_d[dg];
      sb.push_back(pins(act, s, d, bnd));
      if (bnd && pv) begin
        disp_v = pend_v; disp_d = pend_d; pv = 0;
      end
      if (load) begin
        pend_v = value; pend_d = dp_in; pv = 1;
      end
      t++;
    end
  end

  // Monitor: compare every presented output cycle against the queue
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      logic [12:0] e, g;
      e = sb.pop_front();
      g = {an, seg, dp, frame_done};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL scoreboard time=%0t an=%b seg=%h dp=%b fd=%b expected an=%b seg=%h dp=%b fd=%b",
                 $time, g[12:9], g[8:2], g[1], g[0],
                 e[12:9], e[8:2], e[1], e[0]);
      end
    end
  end

  task automatic wait_t(input int m);
    int n = 0;
    while ((t % FR) != m && n < 2 * FR) begin
      @(negedge clk); n++;
    end
    if (n >= 2 * FR) begin
      checks++; errors++;
      $display("FAIL wait_phase got=%0d required=%0d", t % FR, m);
    end
  endtask

  task automatic wait_frame();
    @(negedge clk);
    wait_t(0);
  endtask

  task automatic check_digits(input int first, input logic [27:0] es,
                              input logic [3:0] ed);
    wait_t(8 * first + 3);
    for (int k = first; k < N; k++) begin
      logic [3:0] ea;
      ea = ~(4'b0001 << k);
      checks++;
      if (an !== ea || seg !== es[7*k +: 7] || dp !== ed[k]) begin
        errors++;
        $display("FAIL digit%0d an=%b seg=%h dp=%b required an=%b seg=%h dp=%b",
                 k, an, seg, dp, ea, es[7*k +: 7], ed[k]);
      end
      if (k < N - 1) repeat (R) @(negedge clk);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp_in = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap, n;
    bit seen;
    rst_n = 1'b0; value = '0; dp_in = '0; load = 1'b0; lz_blank = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (an !== 4'b1111 || seg !== 7'h00 || dp !== 1'b0
        || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs an=%b seg=%h dp=%b fd=%b required 1111 00 0 0",
               an, seg, dp, frame_done);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (an !== 4'b1111) begin
      errors++;
      $display("FAIL blank_after_release an=%b required=1111", an);
    end
    @(negedge clk);
    checks++;
    if (an !== 4'b1110) begin
      errors++;
      $display("FAIL first_anode an=%b required=1110", an);
    end

    do_load(16'h12AF, 4'b0000);
    wait_frame();
    check_digits(0, {7'h06, 7'h5B, 7'h77, 7'h71}, 4'b0000);

    n = 0;
    while (frame_done !== 1'b1 && n < 2 * FR) begin
      @(negedge clk); n++;
    end
    gap = 0;
    do begin
      @(negedge clk); gap++;
    end while (frame_done !== 1'b1 && gap < 2 * FR);
    checks++;
    if (gap != FR) begin
      errors++;
      $display("FAIL frame_period got=%0d required=%0d", gap, FR);
    end

    wait_t(12);
    do_load(16'h0000, 4'b0000);
    check_digits(2, {7'h06, 7'h5B, 14'h0}, 4'b0000);
    check_digits(0, {4{7'h3F}}, 4'b0000);

    wait_t(FR - 1);
    do_load(16'h8888, 4'b0000);
    check_digits(0, {4{7'h3F}}, 4'b0000);
    check_digits(0, {4{7'h7F}}, 4'b0000);

    lz_blank = 1'b1;
    do_load(16'h0050, 4'b0000);
    wait_frame();
    check_digits(0, {7'h00, 7'h00, 7'h6D, 7'h3F}, 4'b0000);
    do_load(16'h0000, 4'b0000);
    wait_frame();
    check_digits(0, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000);
    do_load(16'h0000, 4'b1000);
    wait_frame();
    check_digits(0, {7'h3F, 7'h00, 7'h00, 7'h3F}, 4'b1000);

    for (int i = 0; i < 800; i++) begin
      value    = 16'($urandom);
      dp_in    = 4'($urandom);
      load     = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 63) == 0) lz_blank = ~lz_blank;
      @(negedge clk);
    end
    load = 1'b0;

    lz_blank = 1'b0;
    do_load(16'h0000, 4'b0000);
    wait_frame();
    wait_t(20);
    do_load(16'h9876, 4'b0101);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < FR - 2; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL no_frame_done_after_reset got=1 required=0");
    end
    check_digits(0, {4{7'h3F}}, 4'b0000);
    check_digits(0, {4{7'h3F}}, 4'b0000);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_mux.md
Name: seven_seg_mux

Overview:
- Time-multiplexed driver for an N-digit common-anode/cathode seven-segment bank.
- Successor to the single-digit hex decoder:
  - parametrised digit count and output polarities;
  - refresh scanning with anti-ghost blanking;
  - tear-free double-buffered value update;
  - leading-zero suppression and per-digit decimal point.
- Sits between the datapath (ALU result / status registers) and the FPGA display pins.

Parameters:
- N_DIGITS, 4, number of digits; value width is 4*N_DIGITS; legal range 1..8.
- REFRESH_DIV, 50000, clock cycles each digit is selected; must be >= 2.
- BLANK_CYCLES, 500, cycles at the start of each digit slot with all anodes inactive; must be < REFRESH_DIV.
- SEG_ACTIVE_LOW, 0, 1 inverts seg and dp at the pins.
- AN_ACTIVE_LOW, 1, 1 drives the selected anode low.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- value  in  4*N_DIGITS  hex nibbles; digit 0 = bits [3:0], rightmost digit
- dp_in  in  N_DIGITS  decimal point request per digit
- load  in  1  capture value/dp_in into the pending buffer this cycle
- lz_blank  in  1  enable leading-zero suppression
- seg  out  7  segments; bit0=a .. bit6=g (0=0x3F, 1=0x06, ..., F=0x71, active-high before polarity)
- dp  out  1  decimal point of the selected digit
- an  out  N_DIGITS  digit enables, one-hot when active
- frame_done  out  1  one-cycle pulse at the end of each full scan

Behaviour:
- Reset is synchronous on a clk edge with rst_n=0, and takes priority over all other inputs, including mid-frame:
  - div_cnt=0, dig=0;
  - pending and display buffers cleared to 0;
  - pending_valid=0;
  - an, seg and dp all at their inactive levels;
  - frame_done=0.
- Counters:
  - div_cnt counts 0..REFRESH_DIV-1.
  - When div_cnt=REFRESH_DIV-1, it wraps to 0 and dig advances; dig wraps from N_DIGITS-1 to 0.
- Buffering:
  - When load=1, value and dp_in are copied into the pending buffer and pending_valid is set.
  - Frame boundary = dig=N_DIGITS-1 and div_cnt=REFRESH_DIV-1.
  - At a frame boundary with pending_valid=1, the pending buffer is copied to the display buffer and pending_valid is cleared.
  - If load and a frame boundary occur in the same cycle, the old pending contents (if valid) commit. The new value goes into pending with pending_valid=1 and commits at the next boundary.
  - Repeated loads within one frame: the last one wins.
- Leading-zero suppression (lz_blank=1):
  - Digit k is suppressed when every nibble from k up to N_DIGITS-1 in the display buffer is 0 and its dp bit is 0.
  - Digit 0 is never suppressed.
  - A suppressed digit drives seg all-off (and dp off), but its anode still scans.
- Output timing:
  - Outputs are registered: seg/dp/an reflect the counter state of the previous cycle (1-cycle latency).
  - For div_cnt < BLANK_CYCLES, an is all inactive; otherwise an selects dig.
  - seg/dp always show decode(display[dig]) with polarity applied.
  - frame_done is high for exactly the cycle after the frame boundary.
- Polarity: SEG_ACTIVE_LOW and AN_ACTIVE_LOW invert only the final pin values, never the internal state.
- N_DIGITS=1: dig stays 0, and frame_done pulses every REFRESH_DIV cycles.

Test Plan (N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, SEG_ACTIVE_LOW=0, AN_ACTIVE_LOW=1):
- Reset: hold rst_n=0 for 3 cycles, then release.
  - While in reset: an=4'b1111, seg=0x00, dp=0, frame_done=0.
  - First active anode (an=4'b1110) appears 3 cycles after release.
- Scan: load value=16'h12AF and wait 1 frame.
  - Next frame, digits 0..3 show seg 0x71, 0x77, 0x5B, 0x06.
  - Each digit: 2 blank cycles, then 6 active cycles.
  - frame_done pulses every 32 cycles.
- Tear-free update: load 16'h0000 at mid-frame (dig=1).
  - Digits 2 and 3 of the current frame still show old nibbles.
  - The new value appears from digit 0 of the next frame.
- Load at the boundary: load 16'h8888 in the same cycle as the frame boundary, with no prior pending.
  - The display holds the old value for one more frame, then shows 0x7F on all digits.
- Leading-zero blanking: lz_blank=1, value=16'h0050, dp_in=4'b0000.
  - Digits 3 and 2 show seg 0x00; digit 1 shows 0x6D; digit 0 shows 0x3F.
  - Repeat with value=0: only digit 0 shows 0x3F.
  - Repeat with dp_in[3]=1: digit 3 shows 0x3F with dp=1.
- Reset mid-frame: assert rst_n=0 at dig=2, div_cnt=5 with pending_valid=1.
  - After release, dig=0, the display buffer is 0 and the pending value is discarded; no frame_done pulse occurs.
